bw_switch_ctrl: RTL and testbench
=================================

BW_SWITCH_CTRL -- requirements
Module: bw_switch_ctrl

Interface
REQ-001 Parameter GATE_CYC, default 4: clk cycles the clock gate stays closed before the select changes.
REQ-002 Parameter SETTLE_CYC, default 8: clk cycles after the select change before the gate reopens.
REQ-003 Parameter TIMEOUT_CYC, default 1024: maximum wait for lt_idle (used only with the timeout feature).
REQ-004 clk  input  1  single block clock; all state is registered on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 bw_req  input  2  requested bandwidth code: 11 HBR3, 10 HBR2, 01 HBR, 00 RBR.
REQ-007 bw_req_vld  input  1  single-cycle strobe qualifying bw_req.
REQ-008 lt_idle  input  1  link layer reports no symbols in flight.
REQ-009 spm_bw_sel  output  2  registered select driving the downstream link-clock mux.
REQ-010 clk_gate_en  output  1  1 = link clock enabled, 0 = gated.
REQ-011 lt_hold  output  1  request to the link layer to stop traffic.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 bw_switch_done  output  1  one-cycle pulse when a switch completes.
REQ-014 bw_switch_err  output  1  one-cycle pulse on a timeout abort; tied 0 when the timeout feature is compiled out.

Function
REQ-015 The FSM SHALL have the states IDLE, HOLD, GATE, SWITCH, UNGATE and DONE.
REQ-016 IDLE: if bw_req_vld=1 and bw_req differs from spm_bw_sel, latch bw_req into tgt and go to HOLD; if bw_req equals spm_bw_sel, go to DONE with no gating.
REQ-017 HOLD: lt_hold=1; go to GATE on the first cycle lt_idle=1.
REQ-018 GATE: clk_gate_en=0 and lt_hold=1; after GATE_CYC cycles in GATE, go to SWITCH.
REQ-019 SWITCH: spm_bw_sel<=tgt on entry; clk_gate_en stays 0; after SETTLE_CYC cycles, go to UNGATE.
REQ-020 UNGATE: clk_gate_en=1 and lt_hold=1 for one cycle, then go to DONE.
REQ-021 DONE: bw_switch_done=1 and lt_hold=0 for one cycle, then go to IDLE, or to HOLD if a pending request exists.
REQ-022 spm_bw_sel SHALL change only on entry to SWITCH, and only while clk_gate_en=0.
REQ-023 A bw_req_vld arriving while busy=1 SHALL be stored in a single-entry pending register; a later strobe overwrites it (last wins).
REQ-024 Pending service from DONE: if the pending code equals spm_bw_sel, clear it and go to IDLE without a second done pulse; otherwise move it to tgt and go to HOLD.
REQ-025 Counters SHALL be wide enough for the largest parameter and SHALL reset to 0 on every state entry.
REQ-026 GATE_CYC and SETTLE_CYC SHALL each be at least 1; the minimum path IDLE to DONE is 4+GATE_CYC+SETTLE_CYC cycles when lt_idle is already high.

Reset
REQ-027 Reset values: state=IDLE, spm_bw_sel=00, clk_gate_en=1, lt_hold=0, busy=0, bw_switch_done=0, bw_switch_err=0, pending cleared, counters 0.
REQ-028 A reset asserted mid-switch SHALL return to the reset values immediately, including spm_bw_sel=00 even if a switch was in progress.

Configuration
REQ-029 With BW_SW_TIMEOUT_EN defined, a HOLD lasting TIMEOUT_CYC cycles without lt_idle SHALL pulse bw_switch_err, drop lt_hold, keep spm_bw_sel unchanged, clear the pending request and return to IDLE.
REQ-030 Without BW_SW_TIMEOUT_EN, HOLD SHALL wait indefinitely and bw_switch_err SHALL be constant 0.

Verification
REQ-031 From reset, lt_idle=1, bw_req=11 strobed -> spm_bw_sel=11 after GATE_CYC gated cycles, clk_gate_en back to 1, done pulse 16 cycles after the strobe (defaults).
REQ-032 bw_req=00 strobed while spm_bw_sel=00 -> done pulse the next cycle; clk_gate_en and lt_hold never toggle.
REQ-033 Switch to 10 in progress, strobe 01 then 11 -> after the first done, one more switch runs and ends at spm_bw_sel=11 with exactly two done pulses.
REQ-034 lt_idle held 0 for 500 cycles, then 1 -> HOLD persists, then the switch completes normally with no err pulse.
REQ-035 With BW_SW_TIMEOUT_EN, lt_idle held 0 -> err pulse at cycle 1024 of HOLD, spm_bw_sel unchanged, busy=0.
REQ-036 rst asserted during SWITCH -> spm_bw_sel=00, clk_gate_en=1, lt_hold=0, busy=0 asynchronously.

Source files
------------

// File: rtl/bw_switch_ctrl_if.sv
// Bandwidth-switch control bundle.
//
// Groups the request side (bw_req, bw_req_vld), the link-layer status
// (lt_idle) and everything the controller drives back (spm_bw_sel,
// clk_gate_en, lt_hold, busy, bw_switch_done, bw_switch_err).
//
// Handshake: bw_req_vld is a single-cycle strobe. There is no ready;
// a strobe is always accepted. It either starts a switch when the
// controller is idle, or overwrites the single pending slot while busy.
//
// Modports:
//   slave  - the controller (bw_switch_ctrl)
//   master - the requester / link layer side
interface bw_switch_ctrl_if;
  logic [1:0] bw_req;
  logic       bw_req_vld;
  logic       lt_idle;
  logic [1:0] spm_bw_sel;
  logic       clk_gate_en;
  logic       lt_hold;
  logic       busy;
  logic       bw_switch_done;
  logic       bw_switch_err;

  modport slave (
    input  bw_req,
    input  bw_req_vld,
    input  lt_idle,
    output spm_bw_sel,
    output clk_gate_en,
    output lt_hold,
    output busy,
    output bw_switch_done,
    output bw_switch_err
  );

  modport master (
    output bw_req,
    output bw_req_vld,
    output lt_idle,
    input  spm_bw_sel,
    input  clk_gate_en,
    input  lt_hold,
    input  busy,
    input  bw_switch_done,
    input  bw_switch_err
  );
endinterface

// File: rtl/bw_switch_ctrl.sv
// Link-clock bandwidth switch controller.
//
// Sequences a glitch-free change of the link-clock mux select: stop link
// traffic (lt_hold), wait for the link to drain (lt_idle), gate the link
// clock, change the select, let the mux settle, ungate, and pulse done.
// Requests arriving while a switch is in flight are kept in a one-entry
// pending slot (last strobe wins) and serviced from DONE.
//
// Parameters:
//   GATE_CYC    - cycles the gate stays closed before the select changes (>=1)
//   SETTLE_CYC  - cycles after the select change before the gate reopens (>=1)
//   TIMEOUT_CYC - maximum HOLD wait for lt_idle (timeout build only)
//
// Ports:
//   clk       - block clock, rising edge
//   rst       - asynchronous active-high reset
//   bus       - bw_switch_ctrl_if.slave (request, lt_idle, select and status)
//   state_dbg - current FSM state encoding
//
// Optional feature: define BW_SW_TIMEOUT_EN to abort a HOLD that waits
// TIMEOUT_CYC cycles without lt_idle (pulses bw_switch_err). Without it
// HOLD waits forever and bw_switch_err is constant 0.
module bw_switch_ctrl #(
  parameter int GATE_CYC    = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  bw_switch_ctrl_if.slave    bus,
  output logic [2:0]         state_dbg
);

  localparam int MAX_AB  = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_GATE   = 3'd2,
    ST_SWITCH = 3'd3,
    ST_UNGATE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sel_q;
  logic [1:0]       tgt_q, tgt_n;
  logic [1:0]       pend_q;
  logic             pend_vld_q;
  logic             gate_en_q, hold_q, busy_q, done_q;
  logic             tmo;

  // A strobe landing in the DONE cycle itself is folded into the pending
  // decision so it is not lost when DONE clears the slot.
  logic [1:0]       pend_eff;
  logic             pend_eff_vld;

  assign pend_eff     = bus.bw_req_vld ? bus.bw_req : pend_q;
  assign pend_eff_vld = bus.bw_req_vld | pend_vld_q;

  // Next-state logic.
  always_comb begin
    state_n = state;
    tgt_n   = tgt_q;
    tmo     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.bw_req_vld) begin
          if (bus.bw_req != sel_q) begin
            tgt_n   = bus.bw_req;
            state_n = ST_HOLD;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_HOLD: begin
        if (bus.lt_idle) begin
          state_n = ST_GATE;
        end
`ifdef BW_SW_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          tmo     = 1'b1;
          state_n = ST_IDLE;
        end
`endif
      end
      ST_GATE: begin
        if (cnt == CNT_W'(GATE_CYC - 1)) state_n = ST_SWITCH;
      end
      ST_SWITCH: begin
        if (cnt == CNT_W'(SETTLE_CYC - 1)) state_n = ST_UNGATE;
      end
      ST_UNGATE: begin
        state_n = ST_DONE;
      end
      ST_DONE: begin
        // sel_q already holds the new code here, so an equal pending
        // request needs no second pass.
        if (pend_eff_vld && (pend_eff != sel_q)) begin
          tgt_n   = pend_eff;
          state_n = ST_HOLD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, target and per-state counter. The counter restarts on every
  // state change and saturates so an unbounded HOLD cannot wrap it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      tgt_q <= 2'b00;
      cnt   <= '0;
    end else begin
      state <= state_n;
      tgt_q <= tgt_n;
      if (state_n != state) begin
        cnt <= '0;
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Pending slot: written by strobes while busy, emptied by DONE or abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 2'b00;
      pend_vld_q <= 1'b0;
    end else if ((state == ST_DONE) || tmo) begin
      pend_vld_q <= 1'b0;
    end else if ((state != ST_IDLE) && bus.bw_req_vld) begin
      pend_q     <= bus.bw_req;
      pend_vld_q <= 1'b1;
    end
  end

  // Select only moves on entry to SWITCH; the gate has been closed since
  // entry to GATE, so the mux never sees a running clock when it flips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= 2'b00;
    end else if ((state_n == ST_SWITCH) && (state != ST_SWITCH)) begin
      sel_q <= tgt_q;
    end
  end

  // Outputs are registered from the next state so the clock-gate enable
  // comes straight off a flop and cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_en_q <= 1'b1;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      gate_en_q <= !((state_n == ST_GATE) || (state_n == ST_SWITCH));
      hold_q    <= (state_n == ST_HOLD)   || (state_n == ST_GATE) ||
                   (state_n == ST_SWITCH) || (state_n == ST_UNGATE);
      busy_q    <= (state_n != ST_IDLE);
      done_q    <= (state_n == ST_DONE);
    end
  end

`ifdef BW_SW_TIMEOUT_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= tmo;
  end
  assign bus.bw_switch_err = err_q;
`else
  assign bus.bw_switch_err = 1'b0;
`endif

  assign bus.spm_bw_sel     = sel_q;
  assign bus.clk_gate_en    = gate_en_q;
  assign bus.lt_hold        = hold_q;
  assign bus.busy           = busy_q;
  assign bus.bw_switch_done = done_q;
  assign state_dbg          = state;

endmodule

// File: tb/tb_bw_switch_ctrl.sv
// Directed bench for bw_switch_ctrl at default parameters
// (GATE_CYC=4, SETTLE_CYC=8, TIMEOUT_CYC=1024).
// Inputs are driven 1 time unit after a rising edge and outputs are
// checked at the same point, i.e. after the edge has taken effect.
module tb_bw_switch_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_GATE   = 3'd2;
  localparam logic [2:0] S_SWITCH = 3'd3;
  localparam logic [2:0] S_UNGATE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_dbg;
  always #5 clk = ~clk;

  bw_switch_ctrl_if bus ();

  bw_switch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // pulse / toggle monitor, sampled mid-cycle
  int   done_cnt  = 0;
  int   err_cnt   = 0;
  int   gate_tog  = 0;
  int   hold_tog  = 0;
  logic prev_gate = 1'b1;
  logic prev_hold = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bw_switch_done === 1'b1) done_cnt <= done_cnt + 1;
      if (bus.bw_switch_err  === 1'b1) err_cnt  <= err_cnt + 1;
      if (bus.clk_gate_en !== prev_gate) gate_tog <= gate_tog + 1;
      if (bus.lt_hold     !== prev_hold) hold_tog <= hold_tog + 1;
    end
    prev_gate <= bus.clk_gate_en;
    prev_hold <= bus.lt_hold;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] code);
    bus.bw_req     = code;
    bus.bw_req_vld = 1'b1;
    step();
    bus.bw_req_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int i;
    i = 0;
    while (bus.bw_switch_done !== 1'b1 && i < limit) begin
      step();
      i++;
    end
    check(tag, {31'd0, bus.bw_switch_done}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int d0;

  initial begin
    bus.bw_req     = 2'b00;
    bus.bw_req_vld = 1'b0;
    bus.lt_idle    = 1'b1;
    step();
    step();

    // reset values
    check("rst_sel",   bus.spm_bw_sel,     2'b00);
    check("rst_gate",  bus.clk_gate_en,    1'b1);
    check("rst_hold",  bus.lt_hold,        1'b0);
    check("rst_busy",  bus.busy,           1'b0);
    check("rst_done",  bus.bw_switch_done, 1'b0);
    check("rst_err",   bus.bw_switch_err,  1'b0);
    check("rst_state", state_dbg,          S_IDLE);
    rst = 1'b0;
    step();

    // same code as current select: straight to DONE, no gating
    strobe(2'b00);
    check("same_done",  bus.bw_switch_done, 1'b1);
    check("same_state", state_dbg,          S_DONE);
    check("same_gate",  bus.clk_gate_en,    1'b1);
    check("same_hold",  bus.lt_hold,        1'b0);
    step();
    check("same_idle",  state_dbg,          S_IDLE);
    check("same_pulse", bus.bw_switch_done, 1'b0);
    check("same_gtog",  gate_tog,           0);
    check("same_htog",  hold_tog,           0);

    // basic switch 00 -> 11, lt_idle already high.
    // strobe cycle = cycle 0; HOLD 1, GATE 2..5, SWITCH 6..13,
    // UNGATE 14, DONE 15 (16th cycle of the sequence).
    strobe(2'b11);
    check("a_hold_st",  state_dbg,       S_HOLD);
    check("a_hold",     bus.lt_hold,     1'b1);
    check("a_busy",     bus.busy,        1'b1);
    check("a_gate_h",   bus.clk_gate_en, 1'b1);
    step();
    check("a_gate_st",  state_dbg,       S_GATE);
    check("a_gate0",    bus.clk_gate_en, 1'b0);
    repeat (3) step();
    check("a_sel_old",  bus.spm_bw_sel,  2'b00);
    check("a_gate_end", state_dbg,       S_GATE);
    step();
    check("a_sw_st",    state_dbg,       S_SWITCH);
    check("a_sel_new",  bus.spm_bw_sel,  2'b11);
    check("a_sw_gate",  bus.clk_gate_en, 1'b0);
    repeat (7) step();
    check("a_sw_end",   state_dbg,       S_SWITCH);
    step();
    check("a_ug_st",    state_dbg,       S_UNGATE);
    check("a_ug_gate",  bus.clk_gate_en, 1'b1);
    check("a_ug_hold",  bus.lt_hold,     1'b1);
    check("a_ug_nodone", bus.bw_switch_done, 1'b0);
    step();
    check("a_done",     bus.bw_switch_done, 1'b1);
    check("a_done_hold", bus.lt_hold,     1'b0);
    check("a_done_busy", bus.busy,        1'b1);
    step();
    check("a_idle",     state_dbg,       S_IDLE);
    check("a_busy0",    bus.busy,        1'b0);
    check("a_sel_keep", bus.spm_bw_sel,  2'b11);

    // pending equal to the code just reached: one done pulse only
    d0 = done_cnt;
    strobe(2'b10);
    repeat (3) step();
    strobe(2'b10);
    wait_done("d_done", 40);
    check("d_sel",   bus.spm_bw_sel, 2'b10);
    step();
    check("d_idle",  state_dbg,      S_IDLE);
    repeat (20) step();
    check("d_ndone", done_cnt - d0,  1);

    // switch to 10 in progress, strobes 01 then 11: last wins
    do_reset();
    check("c_rst_sel", bus.spm_bw_sel, 2'b00);
    d0 = done_cnt;
    strobe(2'b10);
    repeat (3) step();
    strobe(2'b01);
    step();
    strobe(2'b11);
    wait_done("c_done1", 40);
    check("c_sel1",   bus.spm_bw_sel, 2'b10);
    step();
    check("c_rehold", state_dbg,      S_HOLD);
    wait_done("c_done2", 40);
    check("c_sel2",   bus.spm_bw_sel, 2'b11);
    step();
    check("c_busy0",  bus.busy,       1'b0);
    repeat (20) step();
    check("c_ndone",  done_cnt - d0,  2);

    // lt_idle held low for 500 cycles, then released
    bus.lt_idle = 1'b0;
    strobe(2'b01);
    repeat (500) step();
    check("e_state",  state_dbg,       S_HOLD);
    check("e_hold",   bus.lt_hold,     1'b1);
    check("e_gate",   bus.clk_gate_en, 1'b1);
    check("e_sel",    bus.spm_bw_sel,  2'b11);
    bus.lt_idle = 1'b1;
    wait_done("e_done", 40);
    check("e_sel_new", bus.spm_bw_sel, 2'b01);
    check("e_noerr",  err_cnt,         0);
    step();

    // asynchronous reset in the middle of SWITCH
    strobe(2'b10);
    repeat (5) step();
    check("f_sw_st",  state_dbg,      S_SWITCH);
    check("f_sw_sel", bus.spm_bw_sel, 2'b10);
    step();
    #3;
    rst = 1'b1;
    #1;
    check("f_sel",   bus.spm_bw_sel,  2'b00);
    check("f_gate",  bus.clk_gate_en, 1'b1);
    check("f_hold",  bus.lt_hold,     1'b0);
    check("f_busy",  bus.busy,        1'b0);
    check("f_state", state_dbg,       S_IDLE);
    step();
    rst = 1'b0;
    step();

`ifdef BW_SW_TIMEOUT_EN
    // HOLD abort after TIMEOUT_CYC cycles without lt_idle
    bus.lt_idle = 1'b0;
    strobe(2'b01);
    repeat (1023) step();
    check("t_before", state_dbg,         S_HOLD);
    check("t_noerr",  bus.bw_switch_err, 1'b0);
    step();
    check("t_err",    bus.bw_switch_err, 1'b1);
    check("t_busy",   bus.busy,          1'b0);
    check("t_hold",   bus.lt_hold,       1'b0);
    check("t_sel",    bus.spm_bw_sel,    2'b00);
    step();
    check("t_pulse",  bus.bw_switch_err, 1'b0);
    bus.lt_idle = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
